counter_direction_decoder: RTL

Observes the q output of the up/down counter and recovers the counting behaviour. It reports the count direction, wrap-around events, stalls, resyncs to zero and illegal jumps. It sits on the read side of the counter interface as a checker/consumer, for example for a status display or a self-check monitor. One clock domain, same clock as the counter.

---
 rtl/counter_pkg.sv | 24 ++
 rtl/count_step_classifier.sv | 42 ++++
 rtl/counter_direction_decoder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared types for the up/down counter observer.
//   state_e : decoder FSM states
//   class_e : per-sample classification of a counter transition
package counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [2:0] {
    INIT,
    SYNC,
    UP,
    DOWN,
    FAULT
  } state_e;

  typedef enum logic [2:0] {
    CL_STALL,
    CL_UP,
    CL_DOWN,
    CL_RESYNC,
    CL_ILLEGAL
  } class_e;

endpackage

// File: rtl/count_step_classifier.sv
// Combinational classification of one counter transition prev_q -> q.
// Ports:
//   prev_q  : previously sampled count
//   q       : newly sampled count
//   cls_c   : classification, first match wins (stall, up, down, resync, illegal)
//   wrap_c  : legal step crossed the max<->0 boundary
module count_step_classifier
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] prev_q,
  input  logic [WIDTH-1:0] q,
  output class_e           cls_c,
  output logic             wrap_c
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] delta;

  // Modular difference; wraps naturally at WIDTH bits.
  assign delta = q - prev_q;

  // Priority order matters: max->0 is an up step, never a resync.
  always_comb begin
    cls_c  = CL_ILLEGAL;
    wrap_c = 1'b0;
    if (delta == '0) begin
      cls_c = CL_STALL;
    end else if (delta == WIDTH'(1)) begin
      cls_c  = CL_UP;
      wrap_c = (prev_q == ALL_ONES);
    end else if (delta == ALL_ONES) begin
      cls_c  = CL_DOWN;
      wrap_c = (prev_q == '0);
    end else if (q == '0) begin
      cls_c = CL_RESYNC;
    end
  end

endmodule

// File: rtl/counter_direction_decoder.sv
// Recovers direction, wrap, stall, resync and illegal-jump events from the
// observed q of an up/down counter. All outputs registered, latency 1.
// Ports:
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   sample_en        : q is valid this cycle
//   q                : observed counter value
//   clear_fault      : clears fault latch and illegal-run counter
//   dir_up/dir_valid : recovered direction and its validity
//   step/wrap/stall/resync/illegal : one-cycle classification pulses
//   fault            : sticky, FAULT_LIMIT consecutive illegal samples
//   run_len          : saturating count of legal steps since direction change
module counter_direction_decoder
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned RUN_W       = 8,
  parameter int unsigned FAULT_LIMIT = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] q,
  input  logic             clear_fault,
  output logic             dir_up,
  output logic             dir_valid,
  output logic             step,
  output logic             wrap,
  output logic             stall,
  output logic             resync,
  output logic             illegal,
  output logic             fault,
  output logic [RUN_W-1:0] run_len
);

  localparam int unsigned ICNT_W = $clog2(FAULT_LIMIT + 1);

  state_e             state_q,     state_d;
  logic [WIDTH-1:0]   prev_q,      prev_d;
  logic               dir_up_q,    dir_up_d;
  logic               dir_valid_q, dir_valid_d;
  logic               step_q,      step_d;
  logic               wrap_q,      wrap_d;
  logic               stall_q,     stall_d;
  logic               resync_q,    resync_d;
  logic               illegal_q,   illegal_d;
  logic               fault_q,     fault_d;
  logic [RUN_W-1:0]   run_len_q,   run_len_d;
  logic [ICNT_W-1:0]  icnt_q,      icnt_d;

  class_e cls_c;
  logic   wrap_c;
  logic   do_class_c;
  logic   step_up_c;
  logic   flip_c;

  count_step_classifier #(
    .WIDTH (WIDTH)
  ) u_classifier (
    .prev_q (prev_q),
    .q      (q),
    .cls_c  (cls_c),
    .wrap_c (wrap_c)
  );

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= INIT;
      prev_q      <= '0;
      dir_up_q    <= 1'b0;
      dir_valid_q <= 1'b0;
      step_q      <= 1'b0;
      wrap_q      <= 1'b0;
      stall_q     <= 1'b0;
      resync_q    <= 1'b0;
      illegal_q   <= 1'b0;
      fault_q     <= 1'b0;
      run_len_q   <= '0;
      icnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      dir_up_q    <= dir_up_d;
      dir_valid_q <= dir_valid_d;
      step_q      <= step_d;
      wrap_q      <= wrap_d;
      stall_q     <= stall_d;
      resync_q    <= resync_d;
      illegal_q   <= illegal_d;
      fault_q     <= fault_d;
      run_len_q   <= run_len_d;
      icnt_q      <= icnt_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    dir_up_d    = dir_up_q;
    dir_valid_d = dir_valid_q;
    step_d      = 1'b0;
    wrap_d      = 1'b0;
    stall_d     = 1'b0;
    resync_d    = 1'b0;
    illegal_d   = 1'b0;
    fault_d     = fault_q;
    run_len_d   = run_len_q;
    icnt_d      = icnt_q;

    // A clear in the same cycle as a sample suppresses classification only.
    do_class_c = sample_en && !clear_fault && (state_q != INIT);
    step_up_c  = (cls_c == CL_UP);
    flip_c     = ((state_q == UP) && !step_up_c) || ((state_q == DOWN) && step_up_c);

    if (sample_en) begin
      prev_d = q;
      if (state_q == INIT) begin
        state_d = SYNC;
      end
    end

    if (clear_fault) begin
      fault_d = 1'b0;
      icnt_d  = '0;
      if (state_q == FAULT) begin
        state_d = SYNC;
      end
    end

    if (do_class_c) begin
      stall_d   = (cls_c == CL_STALL);
      step_d    = (cls_c == CL_UP) || (cls_c == CL_DOWN);
      wrap_d    = wrap_c;
      resync_d  = (cls_c == CL_RESYNC);
      illegal_d = (cls_c == CL_ILLEGAL);

      // In FAULT only the pulses are live; tracking state is frozen.
      if (state_q != FAULT) begin
        if (cls_c == CL_ILLEGAL) begin
          run_len_d = '0;
          if (icnt_q >= ICNT_W'(FAULT_LIMIT - 1)) begin
            icnt_d  = ICNT_W'(FAULT_LIMIT);
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            icnt_d = icnt_q + ICNT_W'(1);
          end
        end else begin
          icnt_d = '0;
        end

        case (cls_c)
          CL_UP, CL_DOWN: begin
            if ((state_q == SYNC) || flip_c) begin
              dir_up_d    = step_up_c;
              dir_valid_d = 1'b1;
              run_len_d   = RUN_W'(1);
              state_d     = step_up_c ? UP : DOWN;
            end else if (run_len_q != '1) begin
              run_len_d = run_len_q + RUN_W'(1);
            end
          end
          CL_RESYNC: begin
            dir_valid_d = 1'b0;
            run_len_d   = '0;
            state_d     = SYNC;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign dir_up    = dir_up_q;
  assign dir_valid = dir_valid_q;
  assign step      = step_q;
  assign wrap      = wrap_q;
  assign stall     = stall_q;
  assign resync    = resync_q;
  assign illegal   = illegal_q;
  assign fault     = fault_q;
  assign run_len   = run_len_q;

endmodule
